// File: rtl/sensor_conditioner_pkg.sv
// Shared types and defaults for the parking-lot sensor conditioning stage.
package sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  // 20 ms of stable level at 50 MHz
  localparam int unsigned DB_TICKS_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT    = 24;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: 2-flop synchroniser, debounce FSM with down-counter,
// registered level and one-cycle rise/fall strobes.
module debounce_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned DB_TICKS = DB_TICKS_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_TICKS - 1);

  logic             sync1;
  logic             s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ZERO: begin
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = LOAD;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = ONE;
          rise_nxt  = 1'b1;
        end
      end
      ONE: begin
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = LOAD;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = ZERO;
          fall_nxt  = 1'b1;
        end
      end
      default: state_nxt = ZERO;
    endcase
  end

  // Level and strobes come from the registered next state, so no raw-to-output path exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ZERO;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      db    <= (state_nxt == ONE) || (state_nxt == WAIT0);
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the outer (A) and inner (B) optical-barrier sensors for the
// parking-lot entry/exit state machine; the two channels are independent.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned DB_TICKS = DB_TICKS_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_channel #(
    .DB_TICKS(DB_TICKS),
    .CNT_W   (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .reset(reset),
    .raw  (a_raw),
    .db   (a_db),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_channel #(
    .DB_TICKS(DB_TICKS),
    .CNT_W   (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .reset(reset),
    .raw  (b_raw),
    .db   (b_db),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: a sample-history reference model
// pushes expected outputs each clock; a negedge monitor pops and compares.
module tb_sensor_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned HL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [5:0] exp_q[$];

  // Model state: raw-sample history per channel (index i = sample i edges ago) and level.
  bit hist[2][HL];
  bit lvl[2];
  bit model_started = 1'b0;

  sensor_conditioner #(
    .DB_TICKS(DB),
    .CNT_W   (3)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a_db  (a_db),
    .b_db  (b_db),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  always #5 clk = ~clk;

  // Reference: the level flips on the edge where the last DB+1 synchronised
  // samples (raw delayed two edges) all disagree with the current level.
  always @(posedge clk) begin
    bit raw_in[2];
    bit rs[2];
    bit fl[2];
    bit flip;
    raw_in[0] = a_raw;
    raw_in[1] = b_raw;
    for (int ch = 0; ch < 2; ch++) begin
      rs[ch] = 1'b0;
      fl[ch] = 1'b0;
      if (rst) begin
        for (int i = 0; i < HL; i++) hist[ch][i] = 1'b0;
        lvl[ch] = 1'b0;
      end else begin
        for (int i = HL - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = raw_in[ch];
        flip = 1'b1;
        for (int j = 0; j <= DB; j++)
          if (hist[ch][2+j] == lvl[ch]) flip = 1'b0;
        if (flip) begin
          rs[ch]  = !lvl[ch];
          fl[ch]  = lvl[ch];
          lvl[ch] = !lvl[ch];
        end
      end
    end
    exp_q.push_back({lvl[0], rs[0], fl[0], lvl[1], rs[1], fl[1]});
    model_started = 1'b1;
  end

  always @(negedge clk) begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    if (model_started) begin
      act_v = {a_db, a_rise, a_fall, b_db, b_rise, b_fall};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t actual=%b required=an expected entry", $time, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        // Reset may be raised after the model sampled this edge; outputs must already be 0.
        if (rst) exp_v = '0;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs{a_db,a_rise,a_fall,b_db,b_rise,b_fall} t=%0t actual=%b required=%b",
                   $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic hold(input bit a, input bit b, input int unsigned n);
    a_raw = a;
    b_raw = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int unsigned la, lb;
    bit va, vb;
    @(posedge clk);
    #2;
    // Reset held with both sensors high, then release: fresh rise on both.
    hold(1, 1, 5);
    rst = 1'b0;
    hold(1, 1, 12);
    hold(0, 0, 12);
    // Clean press and release on A.
    hold(1, 0, 10);
    hold(0, 0, 10);
    // Bounce that settles low, then bounce that settles high.
    hold(1, 0, 3); hold(0, 0, 1); hold(1, 0, 3); hold(0, 0, 10);
    hold(1, 0, 3); hold(0, 0, 1); hold(1, 0, 3); hold(0, 0, 1); hold(1, 0, 8);
    hold(0, 0, 10);
    // Short glitches on B.
    hold(0, 1, 1); hold(0, 0, 5); hold(0, 1, 2); hold(0, 0, 5);
    hold(0, 1, 3); hold(0, 0, 10);
    // Car passing: A, then B, then A clears, then B clears.
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    // Simultaneous events on both channels.
    hold(1, 1, 10); hold(0, 0, 10);
    // Reset pulse during the A qualification window.
    hold(1, 0, 2);
    rst = 1'b1;
    hold(1, 0, 1);
    rst = 1'b0;
    hold(1, 0, 10);
    hold(0, 0, 10);
    // DB_TICKS-length boundary pulses (filtered) and DB+1 length (accepted).
    hold(1, 0, DB); hold(0, 0, 10);
    hold(1, 1, DB + 1); hold(0, 0, 12);
    // Random segments with independent per-channel hold lengths.
    la = 0;
    lb = 0;
    va = 1'b0;
    vb = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if (la == 0) begin
        va = !va;
        la = $urandom_range(1, 9);
      end
      if (lb == 0) begin
        vb = !vb;
        lb = $urandom_range(1, 9);
      end
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      hold(va, vb, 1);
      la--;
      lb--;
    end
    rst = 1'b0;
    hold(0, 0, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t actual=still running required=finished", $time);
    $fatal(1);
  end

endmodule
